// File: rtl/spi_slave_param.sv
// Parametrised multi-word SPI slave clocked directly by SCLK, with a handshaked
// transmit holding register and receive valid/overrun/underrun/abort status.
module spi_slave_param #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter bit                    LSB_FIRST  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '0
) (
    input  logic                  SCLK,
    input  logic                  reset,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic [7:0]            word_count,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  abort,
    input  logic                  status_clr
);

    localparam int unsigned     CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} mode_t;

    mode_t                 mode;
    logic [CW-1:0]         bitCnt;
    logic [CW-1:0]         capIdx;
    logic [DATA_WIDTH-1:0] rxShift;
    logic [DATA_WIDTH-1:0] rxNext;
    logic [DATA_WIDTH-1:0] txShift;
    logic [DATA_WIDTH-1:0] txHold;
    logic [DATA_WIDTH-1:0] txAdvanced;
    logic                  txFull;
    logic                  rxPending;
    logic                  boundary;
    logic                  txWrite;

    // The frame state follows CS directly; there is no separate state register.
    always_comb begin
        mode       = CS ? IDLE : SHIFT;
        boundary   = (mode == SHIFT) && (bitCnt == LAST_BIT);
        txWrite    = tx_valid && !txFull;
        capIdx     = LSB_FIRST ? bitCnt : LAST_BIT - bitCnt;
        rxNext     = rxShift;
        rxNext[capIdx] = MOSI;
        txAdvanced = LSB_FIRST ? (txShift >> 1) : (txShift << 1);
        MISO       = (mode == IDLE) ? 1'b0
                   : (LSB_FIRST ? txShift[0] : txShift[DATA_WIDTH-1]);
    end

    assign tx_ready = !txFull;

    always_ff @(posedge SCLK) begin
        if (reset) begin
            bitCnt     <= '0;
            rxShift    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            txShift    <= TX_IDLE;
            txHold     <= '0;
            txFull     <= 1'b0;
            rxPending  <= 1'b0;
            word_count <= '0;
            overrun    <= 1'b0;
            underrun   <= 1'b0;
            abort      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            abort    <= 1'b0;

            // Write and load are exclusive: a write needs the holder empty, a load needs it full.
            if (txWrite) begin
                txHold <= tx_data;
                txFull <= 1'b1;
            end
            if (rx_ack) begin
                rxPending <= 1'b0;
            end

            case (mode)
                IDLE: begin
                    abort      <= (bitCnt != '0);
                    bitCnt     <= '0;
                    word_count <= '0;
                    if (txFull) begin
                        txShift <= txHold;
                        txFull  <= 1'b0;
                    end else begin
                        txShift <= TX_IDLE;
                    end
                end
                SHIFT: begin
                    rxShift <= rxNext;
                    if (boundary) begin
                        rx_data   <= rxNext;
                        rx_valid  <= 1'b1;
                        bitCnt    <= '0;
                        rxPending <= 1'b1;
                        if (word_count != 8'hFF) begin
                            word_count <= word_count + 8'd1;
                        end
                        if (rxPending && !rx_ack) begin
                            overrun <= 1'b1;
                        end
                        if (txFull) begin
                            txShift <= txHold;
                            txFull  <= 1'b0;
                        end else begin
                            txShift  <= TX_IDLE;
                            underrun <= 1'b1;
                        end
                    end else begin
                        txShift <= txAdvanced;
                        bitCnt  <= bitCnt + CW'(1);
                    end
                end
                default: ;
            endcase

            if (status_clr) begin
                overrun  <= 1'b0;
                underrun <= 1'b0;
            end
        end
    end

endmodule
